// File: rtl/fsm_semaforo_multi.sv
// fsm_semaforo_multi
//   N-way traffic-light controller. The approaches are served round-robin
//   according to per-way vehicle sensors. Minimum green, maximum green,
//   yellow and all-red times are counted in prescaler ticks. The tick is a
//   one-cycle enable in the clk domain and is never used as a clock. While
//   the emergency input is held, every approach is driven to red.
// Ports
//   clk      : system clock, every flop updates on the rising edge
//   R        : synchronous active-high reset; it overrides E, T and tick
//   tick     : one-cycle time-base enable
//   T        : per-way vehicle demand (level, 1 = demand)
//   E        : emergency request (level, active-high)
//   verde    : per-way green lamps (registered)
//   amarillo : per-way yellow lamps (registered)
//   rojo     : per-way red lamps (registered)
//   way      : index of the last or current way served
//   emerg    : 1 while the controller is in the emergency state
module fsm_semaforo_multi #(
  parameter int N_WAYS    = 2,
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic                      tick,
  input  logic [N_WAYS-1:0]         T,
  input  logic                      E,
  output logic [N_WAYS-1:0]         verde,
  output logic [N_WAYS-1:0]         amarillo,
  output logic [N_WAYS-1:0]         rojo,
  output logic [$clog2(N_WAYS)-1:0] way,
  output logic                      emerg
);

  localparam int WAY_W = $clog2(N_WAYS);
  localparam int MAX_T = (GREEN_MAX > YELLOW_T) ?
                         ((GREEN_MAX > ALLRED_T) ? GREEN_MAX : ALLRED_T) :
                         ((YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T);

  localparam logic [CNT_W-1:0]  GMIN_M1  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0]  GMAX_M1  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0]  YEL_M1   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0]  ARED_M1  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [N_WAYS-1:0] WAY0_BIT = {{(N_WAYS-1){1'b0}}, 1'b1};

  // Reject parameter sets the timing logic cannot represent.
  if (N_WAYS < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_T < 1 ||
      ALLRED_T < 1 || CNT_W < 1 ||
      (CNT_W < 31 && MAX_T >= (1 << CNT_W))) begin : g_param_check
    $error("fsm_semaforo_multi: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_EMERG   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [N_WAYS-1:0]  verde_q, verde_d;
  logic [N_WAYS-1:0]  amarillo_q, amarillo_d;
  logic [N_WAYS-1:0]  rojo_q, rojo_d;
  logic               emerg_q, emerg_d;

  logic [N_WAYS-1:0]  cur_mask_s;
  logic [N_WAYS-1:0]  nxt_mask_s;
  logic               own_dem_s;
  logic               other_dem_s;
  logic               found_s;
  logic [WAY_W-1:0]   next_way_s;
  logic [WAY_W-1:0]   cand_s;
  logic               green_exit_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // Returns (base + step) mod N_WAYS. step is at most N_WAYS, so one
  // conditional subtraction is enough for any N_WAYS, including non-powers of two.
  function automatic logic [WAY_W-1:0] way_after(input logic [WAY_W-1:0] base,
                                                 input int step);
    int sum;
    sum = int'(base) + step;
    sum = (sum >= N_WAYS) ? (sum - N_WAYS) : sum;
    return WAY_W'(sum);
  endfunction

  // Round-robin search that starts after the current way and tries the current way last.
  always_comb begin
    found_s    = 1'b0;
    next_way_s = way_q;
    cand_s     = way_q;
    for (int i = 1; i <= N_WAYS; i++) begin
      cand_s = way_after(way_q, i);
      if (!found_s && T[cand_s]) begin
        found_s    = 1'b1;
        next_way_s = cand_s;
      end else begin
        found_s    = found_s;
        next_way_s = next_way_s;
      end
    end
  end

  // Next-state, counter and way selection; the lamp pattern is decoded from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    way_d      = way_q;
    cur_mask_s = WAY0_BIT << way_q;
    own_dem_s  = |(T & cur_mask_s);
    other_dem_s = |(T & ~cur_mask_s);
    cnt_inc_s  = cnt_q + CNT_W'(1'b1);
    // Leaving green needs a tick and the minimum time. It also needs another
    // way waiting, and either the current way has gone idle or the maximum
    // green time has run out.
    green_exit_s = tick && (cnt_q >= GMIN_M1) && other_dem_s &&
                   (!own_dem_s || (cnt_q == GMAX_M1));

    case (state_q)
      ST_ALL_RED: begin
        if (E) begin
          state_d = ST_EMERG;
          cnt_d   = CNT_ZERO;
        end else if (tick && (cnt_q == ARED_M1)) begin
          if (found_s) begin
            state_d = ST_GREEN;
            way_d   = next_way_s;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q;       // clearance done, resting until demand
          end
        end else if (tick) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_GREEN: begin
        if (E || green_exit_s) begin
          state_d = ST_YELLOW;
          cnt_d   = CNT_ZERO;
        end else if (tick && (cnt_q != GMAX_M1)) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;           // saturates at GREEN_MAX-1
        end
      end
      ST_YELLOW: begin
        // Yellow always runs to completion, even while E is asserted.
        if (tick && (cnt_q == YEL_M1)) begin
          state_d = ST_ALL_RED;
          cnt_d   = CNT_ZERO;
        end else if (tick) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_EMERG: begin
        if (!E) begin
          state_d = ST_ALL_RED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        cnt_d   = CNT_ZERO;
      end
    endcase

    nxt_mask_s = WAY0_BIT << way_d;
    verde_d    = {N_WAYS{1'b0}};
    amarillo_d = {N_WAYS{1'b0}};
    rojo_d     = {N_WAYS{1'b1}};
    case (state_d)
      ST_GREEN: begin
        verde_d = nxt_mask_s;
        rojo_d  = ~nxt_mask_s;
      end
      ST_YELLOW: begin
        amarillo_d = nxt_mask_s;
        rojo_d     = ~nxt_mask_s;
      end
      default: begin
        rojo_d = {N_WAYS{1'b1}};
      end
    endcase
    emerg_d = (state_d == ST_EMERG);
  end

  // State, timing counter, served way and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= ST_ALL_RED;
      cnt_q      <= CNT_ZERO;
      way_q      <= WAY_W'(N_WAYS - 1);
      verde_q    <= {N_WAYS{1'b0}};
      amarillo_q <= {N_WAYS{1'b0}};
      rojo_q     <= {N_WAYS{1'b1}};
      emerg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      way_q      <= way_d;
      verde_q    <= verde_d;
      amarillo_q <= amarillo_d;
      rojo_q     <= rojo_d;
      emerg_q    <= emerg_d;
    end
  end

  assign verde    = verde_q;
  assign amarillo = amarillo_q;
  assign rojo     = rojo_q;
  assign way      = way_q;
  assign emerg    = emerg_q;

endmodule
